mem_access_unit: RTL and testbench

Memory-stage load/store sequencer for the 32-bit pipelined core. It takes the M-stage load or store, forms a word-aligned bus request with byte enables and lane-replicated store data, and stalls the pipeline until the memory acknowledges. It then registers the raw read word and the size/offset controls into the W stage. The W-stage data selector consumes `ReadDataRawW`, `ByteOffsetW`, `HalfwordOffsetW`, `ByteOrWordW` and `HalfwordW`.

---
 rtl/mem_access_unit.sv | 100 ++++++++++
 tb/tb_mem_access_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store bus sequencer with watchdog and W-stage pipeline registers.
module mem_access_unit #(
  parameter int WATCHDOG = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        ByteOrWordM,
  input  logic        HalfwordM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [3:0]  MemBE,
  output logic [31:0] MemWData,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        StallLSU,
  output logic [31:0] ReadDataRawW,
  output logic [1:0]  ByteOffsetW,
  output logic        HalfwordOffsetW,
  output logic        ByteOrWordW,
  output logic        HalfwordW,
  output logic        LoadValidW,
  output logic        BusErrorW
);
  localparam int CW = $clog2(WATCHDOG + 2);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0] hold, wdata;
  logic [3:0] be;
  logic err, access, load, timeout, done;
  always_comb begin
    access = MemReadM | MemWriteM;
    load = MemReadM & ~MemWriteM;
    done = state == DONE;
    StallLSU = access & ~done;
    timeout = cnt == CW'(WATCHDOG);
    be = !MemWriteM ? 4'b1111 :
         HalfwordM ? (ALUResultM[1] ? 4'b1100 : 4'b0011) :
         ByteOrWordM ? 4'b0001 << ALUResultM[1:0] : 4'b1111;
    wdata = HalfwordM ? {2{WriteDataM[15:0]}} :
            ByteOrWordM ? {4{WriteDataM[7:0]}} : WriteDataM;
    state_nx = state == IDLE ? (access ? REQ : IDLE) :
               state == REQ ? ((MemAck | timeout) ? DONE : REQ) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      hold <= '0;
      err <= 1'b0;
      MemReq <= 1'b0;
      MemWe <= 1'b0;
      MemAddr <= '0;
      MemBE <= '0;
      MemWData <= '0;
      ReadDataRawW <= '0;
      ByteOffsetW <= '0;
      HalfwordOffsetW <= 1'b0;
      ByteOrWordW <= 1'b0;
      HalfwordW <= 1'b0;
      LoadValidW <= 1'b0;
      BusErrorW <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && access) begin
        MemReq <= 1'b1;
        MemWe <= MemWriteM;
        MemAddr <= {ALUResultM[31:2], 2'b00};
        MemBE <= be;
        MemWData <= wdata;
        cnt <= '0;
      end
      if (state == REQ) begin
        if (MemAck) begin
          hold <= MemRData;
          err <= 1'b0;
          MemReq <= 1'b0;
        end else if (timeout) begin
          hold <= '0;
          err <= 1'b1;
          MemReq <= 1'b0;
        end else cnt <= cnt + 1'b1;
      end
      if (!StallLSU) begin
        ReadDataRawW <= (done & load) ? hold : '0;
        LoadValidW <= done & load;
        BusErrorW <= done & err;
        ByteOffsetW <= access ? ALUResultM[1:0] : 2'b00;
        HalfwordOffsetW <= access & ALUResultM[1];
        ByteOrWordW <= ByteOrWordM;
        HalfwordW <= HalfwordM;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of the load/store sequencer with a 7-cycle watchdog.
module tb_mem_access_unit;
  logic clk = 0, reset = 1;
  logic MemReadM = 0, MemWriteM = 0, ByteOrWordM = 0, HalfwordM = 0;
  logic [31:0] ALUResultM = 0, WriteDataM = 0;
  logic MemReq, MemWe, MemAck = 0, StallLSU;
  logic [31:0] MemAddr, MemWData, MemRData = 0, ReadDataRawW;
  logic [3:0] MemBE;
  logic [1:0] ByteOffsetW;
  logic HalfwordOffsetW, ByteOrWordW, HalfwordW, LoadValidW, BusErrorW;
  int checks = 0, errors = 0, n;

  mem_access_unit #(.WATCHDOG(7)) dut (
    .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ByteOrWordM(ByteOrWordM), .HalfwordM(HalfwordM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemBE(MemBE), .MemWData(MemWData), .MemAck(MemAck), .MemRData(MemRData),
    .StallLSU(StallLSU), .ReadDataRawW(ReadDataRawW), .ByteOffsetW(ByteOffsetW),
    .HalfwordOffsetW(HalfwordOffsetW), .ByteOrWordW(ByteOrWordW), .HalfwordW(HalfwordW),
    .LoadValidW(LoadValidW), .BusErrorW(BusErrorW)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic bw, input logic hw,
                       input logic [31:0] a, input logic [31:0] wd);
    MemReadM = rd; MemWriteM = wr; ByteOrWordM = bw; HalfwordM = hw;
    ALUResultM = a; WriteDataM = wd;
  endtask

  initial begin
    tick(); tick();
    reset = 0;
    #1;
    chk("rst_req", MemReq, 0);
    chk("rst_addr", MemAddr, 0);
    chk("rst_be", MemBE, 0);
    chk("rst_we", MemWe, 0);
    chk("rst_wdata", MemWData, 0);
    chk("rst_lv", LoadValidW, 0);
    chk("rst_rd", ReadDataRawW, 0);
    chk("rst_be_err", BusErrorW, 0);
    chk("rst_stall", StallLSU, 0);

    // word load, zero wait states
    drive(1, 0, 0, 0, 32'h100, 0);
    #1 chk("wl_stall0", StallLSU, 1);
    tick();
    chk("wl_req", MemReq, 1);
    chk("wl_be", MemBE, 4'b1111);
    chk("wl_addr", MemAddr, 32'h100);
    chk("wl_we", MemWe, 0);
    chk("wl_stall1", StallLSU, 1);
    MemAck = 1; MemRData = 32'hDEADBEEF;
    tick();
    MemAck = 0;
    chk("wl_req_drop", MemReq, 0);
    chk("wl_stall2", StallLSU, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("wl_rd", ReadDataRawW, 32'hDEADBEEF);
    chk("wl_lv", LoadValidW, 1);
    chk("wl_err", BusErrorW, 0);

    // byte store
    drive(0, 1, 1, 0, 32'h203, 32'h5A);
    tick();
    chk("bs_addr", MemAddr, 32'h200);
    chk("bs_be", MemBE, 4'b1000);
    chk("bs_wdata", MemWData, 32'h5A5A5A5A);
    chk("bs_we", MemWe, 1);
    MemAck = 1;
    tick();
    MemAck = 0;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("bs_lv", LoadValidW, 0);
    chk("bs_boff", ByteOffsetW, 2'b11);

    // halfword load with three wait states
    drive(1, 0, 1, 1, 32'h306, 0);
    MemRData = 32'h12345678;
    tick();
    chk("hl_be", MemBE, 4'b1111);
    chk("hl_addr", MemAddr, 32'h304);
    n = 0;
    while (MemReq && n < 20) begin
      n++;
      MemAck = (n == 4);
      tick();
    end
    MemAck = 0;
    chk("hl_req_cycles", n, 4);
    chk("hl_stall_done", StallLSU, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("hl_hoff", HalfwordOffsetW, 1);
    chk("hl_boff", ByteOffsetW, 2'b10);
    chk("hl_hw", HalfwordW, 1);
    chk("hl_bw", ByteOrWordW, 1);
    chk("hl_lv", LoadValidW, 1);
    chk("hl_rd", ReadDataRawW, 32'h12345678);

    // watchdog timeout
    drive(1, 0, 0, 0, 32'h40, 0);
    tick();
    n = 0;
    while (MemReq && n < 50) begin
      n++;
      tick();
    end
    chk("to_req_cycles", n, 8);
    chk("to_stall_done", StallLSU, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("to_err", BusErrorW, 1);
    chk("to_rd", ReadDataRawW, 0);
    chk("to_lv", LoadValidW, 1);
    tick();
    chk("to_err_clear", BusErrorW, 0);

    // reset during the second REQ cycle
    drive(1, 0, 0, 0, 32'h80, 0);
    tick();
    tick();
    chk("rr_req2", MemReq, 1);
    reset = 1;
    tick();
    chk("rr_req", MemReq, 0);
    chk("rr_stall", StallLSU, 1);
    reset = 0;
    drive(0, 0, 0, 0, 0, 0);
    MemAck = 1; MemRData = 32'hBAD0BAD0;
    #1 chk("rr_stall_nop", StallLSU, 0);
    tick();
    MemAck = 0;
    chk("rr_late_ack_req", MemReq, 0);
    chk("rr_late_ack_lv", LoadValidW, 0);
    chk("rr_late_ack_rd", ReadDataRawW, 0);

    // load, ALU op, store back-to-back
    drive(1, 0, 0, 0, 32'h84, 0);
    #1 chk("bb_ld_stall", StallLSU, 1);
    tick();
    chk("bb_ld_req", MemReq, 1);
    chk("bb_ld_addr", MemAddr, 32'h84);
    MemAck = 1; MemRData = 32'hCAFEF00D;
    tick();
    MemAck = 0;
    tick();
    drive(0, 0, 0, 0, 32'h57, 0);
    chk("bb_ld_lv", LoadValidW, 1);
    chk("bb_ld_rd", ReadDataRawW, 32'hCAFEF00D);
    #1 chk("bb_alu_stall", StallLSU, 0);
    chk("bb_alu_req", MemReq, 0);
    tick();
    drive(0, 1, 0, 0, 32'h400, 32'h11223344);
    chk("bb_alu_lv", LoadValidW, 0);
    chk("bb_alu_boff", ByteOffsetW, 0);
    chk("bb_alu_rd", ReadDataRawW, 0);
    #1 chk("bb_st_stall", StallLSU, 1);
    tick();
    chk("bb_st_req", MemReq, 1);
    chk("bb_st_we", MemWe, 1);
    chk("bb_st_be", MemBE, 4'b1111);
    chk("bb_st_wdata", MemWData, 32'h11223344);
    chk("bb_st_addr", MemAddr, 32'h400);
    MemAck = 1;
    tick();
    MemAck = 0;
    tick();
    chk("bb_st_lv", LoadValidW, 0);

    // upper-halfword store, read+write both set counts as store
    drive(1, 1, 0, 1, 32'h403, 32'h9999ABCD);
    tick();
    chk("hs_be", MemBE, 4'b1100);
    chk("hs_wdata", MemWData, 32'hABCDABCD);
    chk("hs_we", MemWe, 1);
    MemAck = 1;
    tick();
    MemAck = 0;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("hs_lv", LoadValidW, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
